// File: rtl/multi_cycle_mul.sv
// multi_cycle_mul: iterative radix-4 Booth multiplier, 64x64 -> 128 bits, valid/ready handshake.
// Optional build macro MUL_FAST32_EN: 32-bit ops run 17 steps on 34-bit operands.
module multi_cycle_mul (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [1:0]   mul_signed,
  input  logic         mul_32,
  input  logic [63:0]  rs1_data,
  input  logic [63:0]  rs2_data,
  output logic         ready,
  output logic [127:0] mul_result
);

  localparam int unsigned OpW  = 66;
  localparam int unsigned AddW = 68;
  localparam logic [6:0]  DoneFull = 7'd34;
`ifdef MUL_FAST32_EN
  localparam logic [6:0]  DoneFast = 7'd18;
`endif

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_ADD_M,
    BOOTH_ADD_2M,
    BOOTH_SUB_M,
    BOOTH_SUB_2M
  } booth_op_e;

  logic [6:0]     counter_q, counter_d;
  logic [OpW-1:0] m_q, m_d;
  logic [OpW-1:0] p_q, p_d;
  logic [OpW-1:0] q_q, q_d;
  logic           qm1_q, qm1_d;
`ifdef MUL_FAST32_EN
  logic           fast_q, fast_d;
`endif

  logic [6:0]      done_cnt;
  booth_op_e       booth_op;
  logic [AddW-1:0] m_ext, m2_ext, addend, addend_x, p_ext, sum;
  logic            sub;
  logic [127:0]    full_result;

  // Sign/zero extension to the 66-bit datapath. A 32-bit op extended to 34 bits
  // has the same value as its 66-bit extension, so one form serves both modes.
  function automatic logic [OpW-1:0] extend_op(input logic [63:0] v,
                                               input logic        sgn,
                                               input logic        w32);
    logic [OpW-1:0] r;
    if (w32) r = {{34{sgn & v[31]}}, v[31:0]};
    else     r = {{2{sgn & v[63]}}, v};
    return r;
  endfunction

`ifdef MUL_FAST32_EN
  assign done_cnt = fast_q ? DoneFast : DoneFull;
`else
  assign done_cnt = DoneFull;
`endif

  // Booth recoding of the two low multiplier bits plus the guard bit.
  always_comb begin
    booth_op = BOOTH_ZERO;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: booth_op = BOOTH_ADD_M;
      3'b011:         booth_op = BOOTH_ADD_2M;
      3'b100:         booth_op = BOOTH_SUB_2M;
      3'b101, 3'b110: booth_op = BOOTH_SUB_M;
      default:        booth_op = BOOTH_ZERO;
    endcase
  end

  assign m_ext  = {{2{m_q[OpW-1]}}, m_q};
  assign m2_ext = {m_ext[AddW-2:0], 1'b0};
  assign p_ext  = {{2{p_q[OpW-1]}}, p_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (booth_op)
      BOOTH_ADD_M:  addend = m_ext;
      BOOTH_ADD_2M: addend = m2_ext;
      BOOTH_SUB_M:  begin addend = m_ext;  sub = 1'b1; end
      BOOTH_SUB_2M: begin addend = m2_ext; sub = 1'b1; end
      default:      addend = '0;
    endcase
  end

  // Subtraction as ~x + 1, with the +1 folded in as the adder carry-in.
  assign addend_x = sub ? ~addend : addend;
  assign sum      = p_ext + addend_x + {{(AddW-1){1'b0}}, sub};

  always_comb begin
    counter_d = counter_q;
    m_d       = m_q;
    p_d       = p_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
`ifdef MUL_FAST32_EN
    fast_d    = fast_q;
`endif
    if (!valid) begin
      counter_d = '0;
    end else if (counter_q == '0) begin
      m_d       = extend_op(rs1_data, mul_signed[1], mul_32);
      q_d       = extend_op(rs2_data, mul_signed[0], mul_32);
      p_d       = '0;
      qm1_d     = 1'b0;
      counter_d = 7'd1;
`ifdef MUL_FAST32_EN
      fast_d    = mul_32;
`endif
    end else if (counter_q == done_cnt) begin
      counter_d = '0;
      p_d       = '0;
      q_d       = '0;
      qm1_d     = 1'b0;
    end else begin
      // Arithmetic shift of {sum, Q, q_-1} right by two.
      p_d       = sum[AddW-1:2];
      q_d       = {sum[1:0], q_q[OpW-1:2]};
      qm1_d     = q_q[1];
      counter_d = counter_q + 7'd1;
    end
  end

  // NOTE: every state register, multiplicand included, is cleared by reset so an
  // aborted op leaves nothing behind; sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
`ifdef MUL_FAST32_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      counter_q <= counter_d;
      m_q       <= m_d;
      p_q       <= p_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
`ifdef MUL_FAST32_EN
      fast_q    <= fast_d;
`endif
    end
  end

`ifdef MUL_FAST32_EN
  logic [67:0] acc34;
  assign acc34 = {p_q[33:0], q_q[OpW-1:32]};
  assign full_result = fast_q ? {{60{acc34[67]}}, acc34} : {p_q[61:0], q_q};
`else
  assign full_result = {p_q[61:0], q_q};
`endif

  assign ready      = (counter_q == done_cnt);
  assign mul_result = ready ? full_result : '0;

endmodule

// File: tb/tb_multi_cycle_mul.sv
// Directed testbench for multi_cycle_mul: hand-computed products, latency and handshake checks.
module tb_multi_cycle_mul;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [1:0]   mul_signed;
  logic         mul_32;
  logic [63:0]  rs1_data;
  logic [63:0]  rs2_data;
  logic         ready;
  logic [127:0] mul_result;

  int compared;
  int mismatched;

`ifdef MUL_FAST32_EN
  localparam int W32Lat = 18;
`else
  localparam int W32Lat = 34;
`endif

  multi_cycle_mul dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .mul_signed (mul_signed),
    .mul_32     (mul_32),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .ready      (ready),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts negedges until ready is seen; -1 if the budget expires.
  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ready && cycles < budget);
    if (!ready) cycles = -1;
  endtask

  // Runs one op from a negedge with the unit idle; valid held through the ready cycle.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] sg, input logic w32,
                       output int lat, output logic [127:0] res,
                       output logic rdy_after, output logic [127:0] res_after);
    rs1_data   = a;
    rs2_data   = b;
    mul_signed = sg;
    mul_32     = w32;
    valid      = 1'b1;
    wait_ready(100, lat);
    res = mul_result;
    @(negedge clk);
    rdy_after = ready;
    res_after = mul_result;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; mul_signed = 2'b00; mul_32 = 1'b0;
    rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b expected 0", ready); end
    compared++;
    if (mul_result !== 128'd0) begin mismatched++; $display("FAIL reset_result: got %h expected 0", mul_result); end
    // reset wins over a pending request
    valid = 1'b1; rs1_data = 64'd9; rs2_data = 64'd9;
    repeat (3) @(negedge clk);
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_over_valid: got %b expected 0", ready); end
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mulhu();
    int lat; logic [127:0] res, res_after; logic rdy_after;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, lat, res, rdy_after, res_after);
    compared++;
    if (lat !== 34) begin mismatched++; $display("FAIL mulhu_latency: got %0d expected 34", lat); end
    compared++;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      mismatched++; $display("FAIL mulhu_result: got %h expected fffffffffffffffe0000000000000001", res);
    end
    compared++;
    if (rdy_after !== 1'b0) begin mismatched++; $display("FAIL mulhu_ready_one_cycle: got %b expected 0", rdy_after); end
    compared++;
    if (res_after !== 128'd0) begin mismatched++; $display("FAIL mulhu_result_after: got %h expected 0", res_after); end
  endtask

  task automatic test_mulh();
    int lat;
    rs1_data = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data = 64'd5;
    mul_signed = 2'b11; mul_32 = 1'b0; valid = 1'b1;
    repeat (5) @(negedge clk);
    compared++;
    if (ready !== 1'b0 || mul_result !== 128'd0) begin
      mismatched++; $display("FAIL mulh_midop_outputs: got ready=%b result=%h expected 0/0", ready, mul_result);
    end
    wait_ready(100, lat);
    compared++;
    if (lat !== 29) begin mismatched++; $display("FAIL mulh_latency: got %0d expected 29 (34 total)", lat); end
    compared++;
    if (mul_result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB) begin
      mismatched++; $display("FAIL mulh_result: got %h expected ...fffb", mul_result);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_mulhsu();
    int lat; logic [127:0] res, res_after; logic rdy_after;
    do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, lat, res, rdy_after, res_after);
    compared++;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002) begin
      mismatched++; $display("FAIL mulhsu_result: got %h expected fffffffffffffffe0000000000000002", res);
    end
    compared++;
    if (lat !== 34) begin mismatched++; $display("FAIL mulhsu_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_mulw();
    int lat; logic [127:0] res, res_after; logic rdy_after;
    do_op(64'h0000_0000_8000_0000, 64'd2, 2'b11, 1'b1, lat, res, rdy_after, res_after);
    compared++;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000) begin
      mismatched++; $display("FAIL mulw_signed_result: got %h expected ffffffffffffffffffffffff00000000", res);
    end
    compared++;
    if (lat !== W32Lat) begin mismatched++; $display("FAIL mulw_latency: got %0d expected %0d", lat, W32Lat); end
    compared++;
    if (rdy_after !== 1'b0) begin mismatched++; $display("FAIL mulw_ready_one_cycle: got %b expected 0", rdy_after); end
    // upper garbage ignored, unsigned zero extension
    do_op(64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF, 2'b00, 1'b1, lat, res, rdy_after, res_after);
    compared++;
    if (res !== 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001) begin
      mismatched++; $display("FAIL mulw_unsigned_result: got %h expected 0000000000000000fffffffe00000001", res);
    end
    // (3) x (-1) with garbage upper bits, signed
    do_op(64'hFFFF_FFFF_0000_0003, 64'h0000_0000_FFFF_FFFF, 2'b11, 1'b1, lat, res, rdy_after, res_after);
    compared++;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD) begin
      mismatched++; $display("FAIL mulw_neg_result: got %h expected ...fffd", res);
    end
  endtask

  task automatic test_operand_hold();
    int lat;
    rs1_data = 64'd6; rs2_data = 64'd7; mul_signed = 2'b00; mul_32 = 1'b0; valid = 1'b1;
    @(negedge clk);
    rs1_data = 64'hAAAA_5555_AAAA_5555; rs2_data = 64'h8000_0000_0000_0001;
    mul_signed = 2'b11; mul_32 = 1'b1;
    wait_ready(100, lat);
    compared++;
    if (mul_result !== 128'd42) begin mismatched++; $display("FAIL hold_result: got %h expected 2a", mul_result); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("FAIL hold_latency: got %0d expected 33 (34 total)", lat); end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_abort();
    int lat; int seen; logic [127:0] res, res_after; logic rdy_after;
    rs1_data = 64'd100; rs2_data = 64'd100; mul_signed = 2'b11; mul_32 = 1'b0; valid = 1'b1;
    repeat (10) @(negedge clk);
    valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen++;
    end
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL abort_no_ready: got %0d ready cycles expected 0", seen); end
    do_op(64'd3, 64'd7, 2'b11, 1'b0, lat, res, rdy_after, res_after);
    compared++;
    if (res !== 128'd21) begin mismatched++; $display("FAIL abort_restart_result: got %h expected 15", res); end
    compared++;
    if (lat !== 34) begin mismatched++; $display("FAIL abort_restart_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    rs1_data = 64'h0000_0000_0000_1234; rs2_data = 64'h0000_0000_0000_5678;
    mul_signed = 2'b11; mul_32 = 1'b0; valid = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (ready !== 1'b0 || mul_result !== 128'd0) begin
      mismatched++; $display("FAIL midop_reset_outputs: got ready=%b result=%h expected 0/0", ready, mul_result);
    end
    rst = 1'b0; rs1_data = 64'd2; rs2_data = 64'd3;
    wait_ready(100, lat);
    compared++;
    if (lat !== 34) begin mismatched++; $display("FAIL midop_reset_restart_latency: got %0d expected 34", lat); end
    compared++;
    if (mul_result !== 128'd6) begin mismatched++; $display("FAIL midop_reset_restart_result: got %h expected 6", mul_result); end
    // valid stays high: next op latches on the cycle after ready
    rs1_data = 64'hFFFF_FFFF_FFFF_FFF9; rs2_data = 64'd6;
    wait_ready(100, lat);
    compared++;
    if (lat !== 35) begin mismatched++; $display("FAIL b2b_interval: got %0d expected 35", lat); end
    compared++;
    if (mul_result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6) begin
      mismatched++; $display("FAIL b2b_result: got %h expected ...ffd6", mul_result);
    end
    @(negedge clk);
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_one_cycle: got %b expected 0", ready); end
    valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_mulhu();
    test_mulh();
    test_mulhsu();
    test_mulw();
    test_operand_hold();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_cycle_mul.md
# multi_cycle_mul

Iterative radix-4 Booth multiplier for the execute stage, the multiply counterpart of the multicycle divider. It takes two 64-bit register operands and produces the full 128-bit product after a fixed number of cycles. It shares the divider's valid/ready handshake so the EX-stage stall logic treats both units the same way. It covers RV64M MUL/MULH/MULHSU/MULHU and MULW, which uses `mul_32`. Writeback selects the result half and does any 32-bit sign extension.

## Interface
- No parameters; datapath width fixed at 64 (`REG_BUS`).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `valid` in 1: request. Held high by EX for the whole operation, including the cycle `ready` is high.
- `mul_signed` in 2: [1] means rs1 is signed, [0] means rs2 is signed. MUL/MULH = 11, MULHSU = 10, MULHU = 00.
- `mul_32` in 1: operands are taken from bits [31:0] and extended per `mul_signed` (MULW).
- `rs1_data` in 64: multiplicand.
- `rs2_data` in 64: multiplier.
- `ready` out 1: result valid this cycle.
- `mul_result` out 128: full product of the extended operands. Valid only while `ready` is high, 0 otherwise.

## Operation
- Operand extension to 66 bits:
  - 64-bit mode: bit 63 is replicated into [65:64] if that operand is signed, else zeros.
  - `mul_32`: bit 31 is replicated into [65:32] if signed, else zeros.
- State:
  - 7-bit `counter`.
  - 66-bit multiplicand register M.
  - 132-bit accumulator/multiplier register {P_hi, Q} with Booth guard bit q_-1.
- counter==0 with `valid`: M and Q are latched from the extended operands; P_hi = 0, q_-1 = 0.
- Step k (counter 1..33):
  - Decode {Q[1:0], q_-1}:
    - 000/111 → +0
    - 001/010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101/110 → −M
  - Add into P_hi using a 68-bit sign-extended adder; subtraction is ~x + 1.
  - Arithmetic-shift {P_hi, Q, q_-1} right by 2.
- Done state: counter==34.
  - `ready` = 1.
  - `mul_result` = low 128 bits of {P_hi, Q}.
- Counter sequencing:
  - counter==34 with `valid`: next counter = 0 and the accumulator is cleared. The unit is then idle and accepts a new op on the next cycle.
  - `valid` low while counter≠0: operation aborted; counter ← 0, `ready` stays 0.
  - Operands are sampled only at counter==0. Later changes to `rs1_data`, `rs2_data`, `mul_signed` or `mul_32` are ignored until the next start.
- `rst`: counter, M, accumulator and q_-1 ← 0. It takes precedence over `valid` and may occur at any counter value.

## Timing
- Reset values: `ready` = 0, `mul_result` = 0.
- Request first seen at edge T (counter 0): steps run at edges T+1..T+33, and `ready` is high during the cycle after edge T+33 (counter==34). Latency is 34 cycles from the first `valid` cycle.
- `ready` is combinational from counter, high for exactly one cycle per op, then low.
- Back-to-back ops:
  - With `valid` continuously high, the next op latches at the cycle after `ready`.
  - Throughput is one op per 35 cycles.
- No combinational path from `rs1_data`/`rs2_data` to `ready`.

## Configuration
- `MUL_FAST32_EN`, defined: when `mul_32`=1, operands are extended only to 34 bits and 17 steps run. `ready` comes at counter==18, with `mul_result` = 128-bit sign extension of the 68-bit accumulator. The 64-bit ops are unchanged.
- Undefined: every op takes 33 steps and asserts `ready` at counter==34.

## Test plan
- MULHU: rs1 = rs2 = 0xFFFF_FFFF_FFFF_FFFF, `mul_signed`=00 → `mul_result` = 0xFFFFFFFFFFFFFFFE_0000000000000001. `ready` is first high 34 cycles after `valid` and is high for 1 cycle.
- MUL/MULH: rs1 = 0xFFFF_FFFF_FFFF_FFFF (−1), rs2 = 5, `mul_signed`=11 → `mul_result` = 128'hFFFF…FFFB.
- MULHSU: rs1 = 0xFFFF_FFFF_FFFF_FFFE, rs2 = 0xFFFF_FFFF_FFFF_FFFF, `mul_signed`=10 → 0xFFFFFFFFFFFFFFFE_0000000000000002.
- MULW: rs1 = 0x0000_0000_8000_0000, rs2 = 2, `mul_32`=1, `mul_signed`=11 → 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000. `ready` at 34 cycles, or 18 cycles with `MUL_FAST32_EN`.
- Abort: drop `valid` at counter 10 → `ready` never rises, counter 0. Then restart with 3×7 (`mul_signed`=11) → `mul_result` = 21, with `ready` 34 cycles after the restart.
- Reset mid-op: assert `rst` at counter 20 with `valid` high → next cycle counter 0, `ready` 0, `mul_result` 0. Then 2×3 completes in 34 cycles with result 6. Check back-to-back: a second op follows immediately with no idle gap beyond the restart cycle.
